// File: rtl/tt04_wishbone_host_seq.sv
// Host sequencer driving the TT04 pin-level Wishbone bridge protocol.
// Optional WAIT timeout/abort under `TT04_WBHOST_TIMEOUT_EN.
module tt04_wishbone_host_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [2:0]  pin_cmd,
  output logic [7:0]  pin_in8,
  input  logic [7:0]  pin_out8,
  input  logic        pin_valid
);

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_EXEC = 3'b001;
  localparam logic [2:0] CMD_AD0  = 3'b010;
  localparam logic [2:0] CMD_DO0  = 3'b100;
  localparam logic [2:0] CMD_DI0  = 3'b110;

  localparam logic [2:0] EX_RESET   = 3'd1;
  localparam logic [2:0] EX_WBSEL   = 3'd2;
  localparam logic [2:0] EX_DISABLE = 3'd4;
  localparam logic [2:0] EX_ENABLE  = 3'd5;
  localparam logic [2:0] EX_READ    = 3'd6;
  localparam logic [2:0] EX_WRITE   = 3'd7;

  // state = the pin cycle to be emitted at the next clock edge
  localparam logic [3:0] S_INIT_RST = 4'd0;
  localparam logic [3:0] S_INIT_EN  = 4'd1;
  localparam logic [3:0] S_IDLE     = 4'd2;
  localparam logic [3:0] S_ADL      = 4'd3;
  localparam logic [3:0] S_ADH      = 4'd4;
  localparam logic [3:0] S_DO       = 4'd5;
  localparam logic [3:0] S_EXE      = 4'd6;
  localparam logic [3:0] S_WAIT     = 4'd7;
  localparam logic [3:0] S_RD       = 4'd8;
  localparam logic [3:0] S_TO_EN    = 4'd9;
  localparam logic [3:0] S_RESP     = 4'd10;

  typedef struct packed {
    logic        we;
    logic [13:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } req_t;

  function automatic logic [7:0] exec8(
    input logic [2:0] sub
  );
    return {5'b00000, sub};
  endfunction

  logic [3:0]  state;
  logic [1:0]  cnt;
  logic [23:0] rd_q;
  req_t        req_q;

`ifdef TT04_WBHOST_TIMEOUT_EN
  localparam int TB = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = (TB > 8) ? TB : 8;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo;
  logic          err_q;

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT_RST;
      cnt       <= 2'd0;
      rd_q      <= '0;
      req_q     <= '0;
      pin_cmd   <= CMD_IDLE;
      pin_in8   <= 8'h00;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'h0;
`ifdef TT04_WBHOST_TIMEOUT_EN
      tmo       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      pin_cmd   <= CMD_IDLE;
      pin_in8   <= 8'h00;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        S_INIT_RST: begin
          pin_cmd <= CMD_EXEC;
          pin_in8 <= exec8(EX_RESET);
          state   <= S_INIT_EN;
        end
        S_INIT_EN: begin
          pin_cmd <= CMD_EXEC;
          pin_in8 <= exec8(EX_ENABLE);
          state   <= S_IDLE;
        end
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_q <= '{we:  req_we,
                       adr: req_adr,
                       dat: req_dat,
                       sel: req_sel};
            cnt   <= 2'd0;
            if (req_we) begin
              pin_cmd <= CMD_EXEC;
              pin_in8 <= {req_sel, 1'b0, EX_WBSEL};
              state   <= S_ADL;
            end else begin
              pin_cmd <= CMD_AD0;
              pin_in8 <= req_adr[7:0];
              state   <= S_ADH;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_ADL: begin
          pin_cmd <= CMD_AD0;
          pin_in8 <= req_q.adr[7:0];
          state   <= S_ADH;
        end
        S_ADH: begin
          pin_cmd <= CMD_AD0;
          pin_in8 <= {2'b00, req_q.adr[13:8]};
          state   <= req_q.we ? S_DO : S_EXE;
        end
        S_DO: begin
          pin_cmd <= CMD_DO0;
          pin_in8 <= req_q.dat[{cnt, 3'b000} +: 8];
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) state <= S_EXE;
        end
        S_EXE: begin
          pin_cmd <= CMD_EXEC;
          pin_in8 <= exec8(req_q.we ? EX_WRITE : EX_READ);
          state   <= S_WAIT;
`ifdef TT04_WBHOST_TIMEOUT_EN
          tmo     <= '0;
`endif
        end
        S_WAIT: begin
          // pin_cmd still shows EXEC on the first pass: not a WAIT cycle yet
          if (pin_valid && pin_cmd == CMD_IDLE) begin
            if (req_q.we) begin
              rsp_valid <= 1'b1;
              rsp_dat   <= 32'h0;
`ifdef TT04_WBHOST_TIMEOUT_EN
              err_q     <= 1'b0;
`endif
              state     <= S_IDLE;
            end else begin
              pin_cmd <= CMD_DI0;
              cnt     <= 2'd0;
              state   <= S_RD;
            end
          end
`ifdef TT04_WBHOST_TIMEOUT_EN
          else if (pin_cmd == CMD_IDLE) begin
            if (tmo == TMO_LAST) begin
              pin_cmd <= CMD_EXEC;
              pin_in8 <= exec8(EX_DISABLE);
              state   <= S_TO_EN;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
`endif
        end
        S_RD: begin
          cnt     <= cnt + 2'd1;
          pin_cmd <= (cnt < 2'd2) ? CMD_DI0 : CMD_IDLE;
          unique case (cnt)
            2'd0: rd_q[7:0]   <= pin_out8;
            2'd1: rd_q[15:8]  <= pin_out8;
            2'd2: rd_q[23:16] <= pin_out8;
            2'd3: begin
              rsp_valid <= 1'b1;
              rsp_dat   <= {pin_out8, rd_q};
`ifdef TT04_WBHOST_TIMEOUT_EN
              err_q     <= 1'b0;
`endif
              state     <= S_IDLE;
            end
            default: ;
          endcase
        end
`ifdef TT04_WBHOST_TIMEOUT_EN
        S_TO_EN: begin
          pin_cmd <= CMD_EXEC;
          pin_in8 <= exec8(EX_ENABLE);
          state   <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= 1'b1;
          rsp_dat   <= 32'h0;
          err_q     <= 1'b1;
          state     <= S_IDLE;
        end
`endif
        default: state <= S_INIT_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_tt04_wishbone_host_seq.sv
// Directed bench for tt04_wishbone_host_seq with a registered bridge DI model.
// Timeout case runs only when TT04_WBHOST_TIMEOUT_EN is defined.
module tb_tt04_wishbone_host_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [13:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [2:0]  pin_cmd;
  logic [7:0]  pin_in8;
  logic [7:0]  pin_out8 = 8'h00;
  logic        pin_valid;

  logic [31:0] di = 32'h0;
  logic [1:0]  di_idx = 2'd1;
  logic [31:0] pv;

  int n_chk = 0;
  int n_pass = 0;

  assign pv = {21'b0, pin_cmd, pin_in8};

  tt04_wishbone_host_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_adr(req_adr),
    .req_dat(req_dat),
    .req_sel(req_sel),
    .rsp_valid(rsp_valid),
    .rsp_dat(rsp_dat),
    .rsp_err(rsp_err),
    .pin_cmd(pin_cmd),
    .pin_in8(pin_in8),
    .pin_out8(pin_out8),
    .pin_valid(pin_valid)
  );

  always #5 clk = ~clk;

  // bridge: byte0 after a non-DI cycle, then bytes 1..3 per DI0 cycle
  always @(posedge clk) begin
    if (pin_cmd == 3'b110) begin
      pin_out8 <= di[{di_idx, 3'b000} +: 8];
      di_idx   <= di_idx + 2'd1;
    end else begin
      pin_out8 <= di[7:0];
      di_idx   <= 2'd1;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq(input string tag);
    tick;
    chk({tag, "_p0"}, pv, 32'h101);
    chk({tag, "_r0"}, {31'b0, req_ready}, 32'h0);
    tick;
    chk({tag, "_p1"}, pv, 32'h105);
    chk({tag, "_v1"}, {31'b0, rsp_valid}, 32'h0);
    tick;
    chk({tag, "_p2"}, pv, 32'h000);
    chk({tag, "_r2"}, {31'b0, req_ready}, 32'h1);
  endtask

  task automatic put_req(
    input logic        we,
    input logic [13:0] adr,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wr_seq [8];
    logic [31:0] b2_seq [8];
    int bad;
    wr_seq = '{32'h1A2, 32'h234, 32'h212, 32'h4EF,
               32'h4BE, 32'h4AD, 32'h4DE, 32'h107};
    b2_seq = '{32'h1F2, 32'h2BC, 32'h20A, 32'h404,
               32'h403, 32'h402, 32'h401, 32'h107};
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_dat   = '0;
    req_sel   = '0;
    pin_valid = 1'b0;
    #2;
    chk("rst_pins", pv, 32'h0);
    chk("rst_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rspv", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rspd", rsp_dat, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_seq("init");

    // write 0x1234 <- 0xDEADBEEF, sel 0xA; fields scrambled after accept
    put_req(1'b1, 14'h1234, 32'hDEADBEEF, 4'hA);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) begin
        req_valid = 1'b0;
        put_req(1'b0, 14'h3FFF, 32'h0, 4'h0);
        req_valid = 1'b0;
      end
      chk($sformatf("wr_pin%0d", i), pv, wr_seq[i]);
    end
    chk("wr_busy", {31'b0, req_ready}, 32'h0);
    pin_valid = 1'b1;
    tick;
    pin_valid = 1'b0;
    chk("wr_exe_vld_ign", {31'b0, rsp_valid}, 32'h0);
    chk("wr_wait_pin", pv, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("wr_wait%0d", i), {31'b0, rsp_valid}, 32'h0);
    end
    pin_valid = 1'b1;
    tick;
    pin_valid = 1'b0;
    chk("wr_rspv", {31'b0, rsp_valid}, 32'h1);
    chk("wr_rspd", rsp_dat, 32'h0);
    chk("wr_err", {31'b0, rsp_err}, 32'h0);
    tick;
    chk("wr_pulse", {31'b0, rsp_valid}, 32'h0);
    chk("wr_ready", {31'b0, req_ready}, 32'h1);

    // read 0x0004, bridge data 0x11223344
    di = 32'h11223344;
    put_req(1'b0, 14'h0004, 32'h0, 4'h0);
    tick;
    req_valid = 1'b0;
    chk("rd_adl", pv, 32'h204);
    tick;
    chk("rd_adh", pv, 32'h200);
    tick;
    chk("rd_exe", pv, 32'h106);
    tick;
    chk("rd_wait", pv, 32'h0);
    tick;
    tick;
    pin_valid = 1'b1;
    tick;
    pin_valid = 1'b0;
    chk("rd_di1", pv, 32'h600);
    tick;
    chk("rd_di2", pv, 32'h600);
    tick;
    chk("rd_di3", pv, 32'h600);
    tick;
    chk("rd_idle", pv, 32'h0);
    chk("rd_early", {31'b0, rsp_valid}, 32'h0);
    tick;
    chk("rd_rspv", {31'b0, rsp_valid}, 32'h1);
    chk("rd_rspd", rsp_dat, 32'h11223344);
    tick;
    chk("rd_hold", rsp_dat, 32'h11223344);
    chk("rd_ready", {31'b0, req_ready}, 32'h1);

    // back-to-back: read 0x2A5 then write held on req_valid
    di = 32'hCAFEF00D;
    put_req(1'b0, 14'h02A5, 32'h0, 4'h0);
    tick;
    put_req(1'b1, 14'h0ABC, 32'h01020304, 4'hF);
    chk("b2_adl", pv, 32'h2A5);
    tick;
    chk("b2_adh", pv, 32'h202);
    tick;
    chk("b2_exe", pv, 32'h106);
    tick;
    pin_valid = 1'b1;
    tick;
    pin_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("b2_busy", {31'b0, req_ready}, 32'h0);
    tick;
    chk("b2_rspv", {31'b0, rsp_valid}, 32'h1);
    chk("b2_rspd", rsp_dat, 32'hCAFEF00D);
    chk("b2_nordy", {31'b0, req_ready}, 32'h0);
    tick;
    chk("b2_gap", pv, 32'h0);
    chk("b2_ready", {31'b0, req_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) req_valid = 1'b0;
      chk($sformatf("b2_pin%0d", i), pv, b2_seq[i]);
    end
    tick;
    pin_valid = 1'b1;
    tick;
    pin_valid = 1'b0;
    chk("b2_wrv", {31'b0, rsp_valid}, 32'h1);
    chk("b2_wrd", rsp_dat, 32'h0);
    tick;

`ifdef TT04_WBHOST_TIMEOUT_EN
    // no valid from the bridge: abort after 16 WAIT cycles
    put_req(1'b0, 14'h0010, 32'h0, 4'h0);
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (pv != 32'h0 || rsp_valid) bad++;
    end
    chk("to_wait", bad, 32'h0);
    tick;
    chk("to_dis", pv, 32'h104);
    tick;
    chk("to_en", pv, 32'h105);
    tick;
    chk("to_rspv", {31'b0, rsp_valid}, 32'h1);
    chk("to_err", {31'b0, rsp_err}, 32'h1);
    chk("to_rspd", rsp_dat, 32'h0);
    tick;
    chk("to_ready", {31'b0, req_ready}, 32'h1);
`endif

    // async reset during DO0 byte 2
    put_req(1'b1, 14'h0155, 32'h55AA55AA, 4'h3);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("ar_do2", pv, 32'h4AA);
    rst = 1'b1;
    #1;
    chk("ar_pins", pv, 32'h0);
    chk("ar_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_seq("reinit");
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (rsp_valid || pv != 32'h0) bad++;
    end
    chk("ar_norsp", bad, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
